// File: rtl/sync_sample_fifo.sv
// Single-clock sample FIFO with exact fill count, threshold flags, registered read
// data with a valid strobe, and sticky overflow/underflow error flags.
module sync_sample_fifo #(
  parameter int unsigned FIFO_WIDTH     = 14,
  parameter int unsigned FIFO_DEPTH     = 64,
  parameter int unsigned ALMST_FULL_TH  = 59,
  parameter int unsigned ALMST_EMPTY_TH = 5,
  localparam int unsigned CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almst_full,
  output logic                  fifo_almst_empty,
  output logic                  fifo_above_half,
  output logic [CW-1:0]         fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] ram [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags decoded straight from the registered count
  assign fifo_full        = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty       = (fifo_count == CW'(0));
  assign fifo_almst_full  = (fifo_count >= CW'(ALMST_FULL_TH));
  assign fifo_almst_empty = (fifo_count <= CW'(ALMST_EMPTY_TH));
  assign fifo_above_half  = (fifo_count >  CW'(FIFO_DEPTH / 2));

  assign wr_acc = wr_en & ~fifo_full;
  assign rd_acc = rd_en & ~fifo_empty;

  // Storage array: no reset so it can map onto RAM primitives
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      ram[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_data <= ram[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A new fault in the same cycle takes priority over the clear
      overflow  <= (wr_en & fifo_full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & fifo_empty) | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sync_sample_fifo.sv
// Bench for sync_sample_fifo (depth 8): directed scenarios plus randomized traffic
// checked against a queue-based occupancy model.
module tb_sync_sample_fifo;

  localparam int unsigned W  = 14;
  localparam int unsigned D  = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 1;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic          clr_err;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_almst_full;
  logic          fifo_almst_empty;
  logic          fifo_above_half;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_rd_data;
  logic         m_rd_valid;
  logic         m_ov;
  logic         m_un;

  sync_sample_fifo #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .ALMST_FULL_TH(AF), .ALMST_EMPTY_TH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almst_full(fifo_almst_full), .fifo_almst_empty(fifo_almst_empty),
    .fifo_above_half(fifo_above_half), .fifo_count(fifo_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_flags();
    int n = q.size();
    return {n == D, n == 0, n >= AF, n <= AE, n > D / 2};
  endfunction

  function automatic logic [4:0] dut_flags();
    return {fifo_full, fifo_empty, fifo_almst_full, fifo_almst_empty, fifo_above_half};
  endfunction

  // One clock of stimulus; the model advances on the same edge; outputs settle #1 later
  task automatic cyc(input logic wr, input logic [W-1:0] wd, input logic rd, input logic clr);
    logic full_now, empty_now;
    @(negedge clk);
    rst = 1'b0; wr_en = wr; wr_data = wd; rd_en = rd; clr_err = clr;
    @(posedge clk);
    full_now  = (q.size() == D);
    empty_now = (q.size() == 0);
    m_rd_valid = rd && !empty_now;
    if (rd && !empty_now) m_rd_data = q.pop_front();
    if (wr && !full_now) q.push_back(wd);
    m_ov = (wr && full_now)  || (m_ov && !clr);
    m_un = (rd && empty_now) || (m_un && !clr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    @(posedge clk);
    q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_checks++;
    if (fifo_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_checks++;
    if (dut_flags() !== 5'b01010) begin n_fail++; $display("FAIL reset_flags got=%b exp=01010", dut_flags()); end
    n_checks++;
    if ({rd_valid, overflow, underflow, rd_data} !== {3'b000, W'(0)}) begin
      n_fail++; $display("FAIL reset_outputs got v=%b ov=%b un=%b d=%h exp all 0", rd_valid, overflow, underflow, rd_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== CW'(i)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", fifo_count, i); end
    end
    n_checks++;
    if (dut_flags() !== 5'b10101) begin n_fail++; $display("FAIL fill_flags got=%b exp=10101", dut_flags()); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
        n_fail++; $display("FAIL drain_data got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, W'(i));
      end
    end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({underflow, rd_valid, rd_data} !== {2'b10, W'(8)}) begin
      n_fail++; $display("FAIL drain_underflow got un=%b v=%b d=%h exp un=1 v=0 d=008", underflow, rd_valid, rd_data);
    end
  endtask

  task automatic test_full_wr_rd();
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(16 + i), 1'b0, 1'b0);
    cyc(1'b1, W'(14'h3ff), 1'b1, 1'b0);
    n_checks++;
    if ({overflow, fifo_count, rd_valid, rd_data} !== {1'b1, CW'(7), 1'b1, W'(16)}) begin
      n_fail++; $display("FAIL full_wr_rd got ov=%b cnt=%0d v=%b d=%h exp ov=1 cnt=7 v=1 d=010",
                         overflow, fifo_count, rd_valid, rd_data);
    end
  endtask

  task automatic test_clr_err();
    cyc(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_plain got=%b exp=0", overflow); end
    cyc(1'b1, W'(5), 1'b0, 1'b0);
    cyc(1'b1, W'(6), 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set got=%b exp=1", overflow); end
  endtask

  task automatic test_empty_wr_rd();
    do_reset();
    cyc(1'b1, W'(14'h155), 1'b1, 1'b0);
    n_checks++;
    if ({underflow, fifo_count, rd_valid} !== {1'b1, CW'(1), 1'b0}) begin
      n_fail++; $display("FAIL empty_wr_rd got un=%b cnt=%0d v=%b exp un=1 cnt=1 v=0", underflow, fifo_count, rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, W'($urandom), 1'b1, 1'b0);
      n_checks++;
      if (fifo_count !== CW'(3) || rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
        n_fail++; $display("FAIL b2b[%0d] got cnt=%0d v=%b d=%h exp cnt=3 v=1 d=%h", i, fifo_count, rd_valid, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(32 + i), 1'b0, 1'b0);
    do_reset();
    n_checks++;
    if ({fifo_count, fifo_empty, rd_valid, overflow, underflow} !== {CW'(0), 4'b1000}) begin
      n_fail++; $display("FAIL rst_mid got cnt=%0d e=%b v=%b ov=%b un=%b exp cnt=0 e=1 rest 0",
                         fifo_count, fifo_empty, rd_valid, overflow, underflow);
    end
    cyc(1'b1, W'(14'h2ab), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== W'(14'h2ab)) begin
      n_fail++; $display("FAIL rst_mid_data got v=%b d=%h exp v=1 d=2ab", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Bias write/read probability per phase so the fill level sweeps the whole range
      int pw = (i % 100 < 50) ? 75 : 25;
      cyc(($urandom % 100) < pw, W'($urandom), ($urandom % 100) < (100 - pw), ($urandom % 16) == 0);
      n_checks++;
      if (fifo_count !== CW'(q.size()) || dut_flags() !== exp_flags() ||
          rd_valid !== m_rd_valid || overflow !== m_ov || underflow !== m_un ||
          rd_data !== m_rd_data) begin
        n_fail++;
        $display("FAIL random[%0d] got cnt=%0d fl=%b v=%b ov=%b un=%b d=%h exp cnt=%0d fl=%b v=%b ov=%b un=%b d=%h",
                 i, fifo_count, dut_flags(), rd_valid, overflow, underflow, rd_data,
                 q.size(), exp_flags(), m_rd_valid, m_ov, m_un, m_rd_data);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_wr_rd();
    test_clr_err();
    test_empty_wr_rd();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
